// File: rtl/gnr_pkg.sv
// Shared constants, sizing helper and config word type for the GNR node fabric.
// No logic; imported by every node file.
package gnr_pkg;

   localparam int GNR_MAX_IN = 6;

   // Widest truth table any node can hold; narrower nodes use the low bits.
   typedef logic [(1 << GNR_MAX_IN)-1:0] gnr_cfg_t;

   // Bits needed to count 0..n-1, never less than one.
   function automatic int clog2_min1(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/gnr_lut_eval.sv
// Truth-table lookup: selects lut[idx] for one trajectory's regulator vector.
// Latency: combinational. Backpressure: none.
module gnr_lut_eval
   import gnr_pkg::*;
#(
   parameter int NUM_IN = 4
) (
   input  logic [(1 << NUM_IN)-1:0] lut,
   input  logic [NUM_IN-1:0]        idx,
   output logic                     out_bit
);

   assign out_bit = lut[idx];

endmodule

// File: rtl/gnr_node_lut.sv
// Boolean-network node: slow/fast trajectories stepped through a loadable LUT, with eq flag and flip counter.
// Latency: one clk from start_* to s0/s1/eq/flip_cnt. Backpressure: none, every start is consumed.
module gnr_node_lut
   import gnr_pkg::*;
#(
   parameter int NUM_IN   = 4,
   parameter int SLOW_DIV = 2,
   parameter int CNT_W    = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     cfg_we,
   input  logic [(1 << NUM_IN)-1:0] cfg_lut,
   input  logic                     reset_nos,
   input  logic                     init_state,
   input  logic                     start_s0,
   input  logic                     start_s1,
   input  logic [NUM_IN-1:0]        in_s0,
   input  logic [NUM_IN-1:0]        in_s1,
   output logic                     s0,
   output logic                     s1,
   output logic                     apc_s0,
   output logic                     apc_s1,
   output logic                     eq,
   output logic [CNT_W-1:0]         flip_cnt
);

   localparam int LUT_W = 1 << NUM_IN;
   localparam int PH_W  = clog2_min1(SLOW_DIV);
   localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(SLOW_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   logic [LUT_W-1:0] lut_q, lut_d;
   logic [PH_W-1:0]  phase_q, phase_d;
   logic             s0_q, s0_d;
   logic             s1_q, s1_d;
   logic             eq_q, eq_d;
   logic [CNT_W-1:0] flip_cnt_q, flip_cnt_d;
   logic             nxt_s0, nxt_s1;

   // Both lookups read the registered table, so a same-edge cfg_we never affects a step.
   gnr_lut_eval #(.NUM_IN(NUM_IN)) u_eval_s0 (
      .lut     (lut_q),
      .idx     (in_s0),
      .out_bit (nxt_s0)
   );

   gnr_lut_eval #(.NUM_IN(NUM_IN)) u_eval_s1 (
      .lut     (lut_q),
      .idx     (in_s1),
      .out_bit (nxt_s1)
   );

   always_comb begin
      lut_d      = lut_q;
      phase_d    = phase_q;
      s0_d       = s0_q;
      s1_d       = s1_q;
      eq_d       = eq_q;
      flip_cnt_d = flip_cnt_q;

      if (cfg_we) lut_d = cfg_lut;

      if (reset_nos) begin
         // Phase parked on its last value so the first start after re-init updates s0.
         s0_d       = init_state;
         s1_d       = init_state;
         phase_d    = PH_LAST;
         eq_d       = 1'b1;
         flip_cnt_d = '0;
      end else begin
         if (start_s0) begin
            if (phase_q == PH_LAST) begin
               s0_d    = nxt_s0;
               phase_d = '0;
            end else begin
               phase_d = phase_q + PH_W'(1);
            end
         end
         if (start_s1) begin
            s1_d = nxt_s1;
            if ((nxt_s1 != s1_q) && (flip_cnt_q != CNT_MAX)) begin
               flip_cnt_d = flip_cnt_q + CNT_W'(1);
            end
         end
         if (start_s0 || start_s1) eq_d = (s0_d == s1_d);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lut_q      <= '0;
         phase_q    <= '0;
         s0_q       <= 1'b0;
         s1_q       <= 1'b0;
         eq_q       <= 1'b1;
         flip_cnt_q <= '0;
      end else begin
         lut_q      <= lut_d;
         phase_q    <= phase_d;
         s0_q       <= s0_d;
         s1_q       <= s1_d;
         eq_q       <= eq_d;
         flip_cnt_q <= flip_cnt_d;
      end
   end

   assign s0       = s0_q;
   assign s1       = s1_q;
   assign apc_s0   = s0_q;
   assign apc_s1   = s1_q;
   assign eq       = eq_q;
   assign flip_cnt = flip_cnt_q;

endmodule

// File: tb/tb_gnr_node_lut.sv
// Directed bench: two single-input nodes wired as self-loops (wide and 2-bit flip counters) share one stimulus.
module tb_gnr_node_lut;

   logic       clk;
   logic       rst_n;
   logic       cfg_we;
   logic [1:0] cfg_lut;
   logic       reset_nos;
   logic       init_state;
   logic       start_s0;
   logic       start_s1;

   logic        a_s0, a_s1, a_apc_s0, a_apc_s1, a_eq;
   logic [15:0] a_flip;
   logic        b_s0, b_s1, b_apc_s0, b_apc_s1, b_eq;
   logic [1:0]  b_flip;

   int n_chk;
   int n_fail;

   gnr_node_lut #(.NUM_IN(1), .SLOW_DIV(2), .CNT_W(16)) dut_a (
      .clk        (clk),
      .rst_n      (rst_n),
      .cfg_we     (cfg_we),
      .cfg_lut    (cfg_lut),
      .reset_nos  (reset_nos),
      .init_state (init_state),
      .start_s0   (start_s0),
      .start_s1   (start_s1),
      .in_s0      (a_apc_s0),
      .in_s1      (a_apc_s1),
      .s0         (a_s0),
      .s1         (a_s1),
      .apc_s0     (a_apc_s0),
      .apc_s1     (a_apc_s1),
      .eq         (a_eq),
      .flip_cnt   (a_flip)
   );

   gnr_node_lut #(.NUM_IN(1), .SLOW_DIV(2), .CNT_W(2)) dut_b (
      .clk        (clk),
      .rst_n      (rst_n),
      .cfg_we     (cfg_we),
      .cfg_lut    (cfg_lut),
      .reset_nos  (reset_nos),
      .init_state (init_state),
      .start_s0   (start_s0),
      .start_s1   (start_s1),
      .in_s0      (b_apc_s0),
      .in_s1      (b_apc_s1),
      .s0         (b_s0),
      .s1         (b_s1),
      .apc_s0     (b_apc_s0),
      .apc_s1     (b_apc_s1),
      .eq         (b_eq),
      .flip_cnt   (b_flip)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      cfg_we    = 1'b0;
      reset_nos = 1'b0;
      start_s0  = 1'b0;
      start_s1  = 1'b0;
   endtask

   // s1 values expected from the NOT loop starting at 0
   logic [3:0] not_seq;
   // s0 values expected from the divided NOT loop
   logic [4:0] tort_seq;
   // eq after combined steps
   logic [3:0] eq_seq;

   initial begin
      n_chk      = 0;
      n_fail     = 0;
      rst_n      = 1'b0;
      cfg_lut    = 2'b00;
      init_state = 1'b0;
      idle();
      not_seq  = 4'b0101;   // bit k = value after step k
      tort_seq = 5'b10011;
      eq_seq   = 4'b1001;

      repeat (2) step();
      rst_n = 1'b1;
      step();
      chk("rst_s0", a_s0, 0);
      chk("rst_s1", a_s1, 0);
      chk("rst_eq", a_eq, 1);
      chk("rst_flip", a_flip, 0);

      // Load NOT truth table, re-init trajectories at 0
      cfg_we = 1'b1; cfg_lut = 2'b01;
      step();
      idle();
      reset_nos = 1'b1; init_state = 1'b0;
      step();
      idle();
      chk("nos_s1", a_s1, 0);
      chk("nos_eq", a_eq, 1);

      // Fast trajectory toggles; wide counter counts, 2-bit counter saturates
      start_s1 = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         chk($sformatf("not_s1_%0d", k), a_s1, not_seq[k]);
         chk($sformatf("not_apc_s1_%0d", k), a_apc_s1, not_seq[k]);
         chk($sformatf("not_eq_%0d", k), a_eq, !not_seq[k]);
      end
      chk("not_flip4", a_flip, 4);
      step();
      chk("sat_s1_5", b_s1, 1);
      chk("wide_flip5", a_flip, 5);
      chk("sat_flip5", b_flip, 3);
      idle();
      step();
      chk("hold_s1", a_s1, 1);
      chk("hold_flip", a_flip, 5);

      // Tortoise: s0 updates on every second start_s0
      reset_nos = 1'b1;
      step();
      idle();
      start_s0 = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step();
         chk($sformatf("tort_s0_%0d", k), a_s0, tort_seq[k]);
      end
      chk("tort_s1_idle", a_s1, 0);
      idle();
      reset_nos = 1'b1;
      step();
      idle();
      chk("tort_nos_s0", a_s0, 0);
      start_s0 = 1'b1;
      step();
      idle();
      chk("tort_first_after_nos", a_s0, 1);

      // Detection: both trajectories stepped each cycle
      reset_nos = 1'b1;
      step();
      idle();
      start_s0 = 1'b1; start_s1 = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         chk($sformatf("det_eq_%0d", k), a_eq, eq_seq[k]);
      end
      idle();

      // Cfg race: start on the load edge still uses the old (all-zero) table
      cfg_we = 1'b1; cfg_lut = 2'b00;
      step();
      idle();
      reset_nos = 1'b1;
      step();
      idle();
      cfg_we = 1'b1; cfg_lut = 2'b11; start_s1 = 1'b1;
      step();
      idle();
      chk("race_old_lut", a_s1, 0);
      start_s1 = 1'b1;
      step();
      idle();
      chk("race_new_lut", a_s1, 1);
      chk("race_flip", a_flip, 1);
      chk("race_eq", a_eq, 0);

      // reset_nos beats a simultaneous start (table would yield 1)
      reset_nos = 1'b1; init_state = 1'b0; start_s0 = 1'b1; start_s1 = 1'b1;
      step();
      idle();
      chk("pri_s0", b_s0, 0);
      chk("pri_s1", b_s1, 0);
      chk("pri_flip", b_flip, 0);
      chk("pri_eq", b_eq, 1);

      // Async reset mid-cycle, no clock edge needed
      start_s1 = 1'b1;
      step();
      idle();
      chk("pre_arst_s1", a_s1, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_s0", a_s0, 0);
      chk("arst_s1", a_s1, 0);
      chk("arst_eq", a_eq, 1);
      chk("arst_flip", a_flip, 0);
      rst_n = 1'b1;
      // Table cleared by reset: a step from 0 now yields 0
      start_s1 = 1'b1;
      step();
      idle();
      chk("arst_lut_cleared", a_s1, 0);
      chk("arst_flip_after", a_flip, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
